fb_write_arbiter: RTL

//  Shares the 1-bit VGA frame-buffer write port (write_x/write_y/write_value) among NUM_REQ pixel producers.

---
 rtl/fb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/fb_write_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, FSM state encoding and pixel payload type.
package fb_pkg;

    localparam int unsigned FB_X_W    = 8;
    localparam int unsigned FB_Y_W    = 8;
    localparam int unsigned FB_WIDTH  = 256;
    localparam int unsigned FB_HEIGHT = 256;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic [FB_X_W-1:0] x;
        logic [FB_Y_W-1:0] y;
        logic              value;
    } pixel_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Search upward from ptr+1 (mod N) for the first active request.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        grant_onehot[grant_idx] = found;
    end

    // Pointer starts at N-1 so requester 0 wins first; moves only on a transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= IDX_W'(N - 1);
        end else if (advance) begin
            ptr_q <= grant_idx;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write port sharing: round-robin producer arbitration plus a
// full-buffer clear sweep, with a saturating count of producer writes.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned X_W         = FB_X_W,
    parameter int unsigned Y_W         = FB_Y_W,
    parameter int unsigned FB_WIDTH    = fb_pkg::FB_WIDTH,
    parameter int unsigned FB_HEIGHT   = fb_pkg::FB_HEIGHT,
    parameter logic        CLEAR_VALUE = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    input  logic [NUM_REQ-1:0]     req_value,
    input  logic                   clear_start,
    output logic                   clear_busy,
    output logic                   write_en,
    output logic [X_W-1:0]         write_x,
    output logic [Y_W-1:0]         write_y,
    output logic                   write_value,
    output logic [23:0]            write_count
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W  = 24;
    localparam logic [X_W-1:0]   X_LAST  = X_W'(FB_WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(FB_HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state_q, state_d;

    logic [X_W-1:0]   sx_q, sx_d;
    logic [Y_W-1:0]   sy_q, sy_d;
    logic             we_q, we_d;
    logic [X_W-1:0]   wx_q, wx_d;
    logic [Y_W-1:0]   wy_q, wy_d;
    logic             wv_q, wv_d;
    logic             busy_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic [NUM_REQ-1:0] grant_onehot;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_ok;
    logic               transfer;
    logic               sweep_last;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic               sel_value;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clock        (clock),
        .reset        (reset),
        .req          (req_valid),
        .advance      (transfer),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    // Payload mux for the granted producer.
    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_value = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == grant_idx) begin
                sel_x     = req_x[i*X_W +: X_W];
                sel_y     = req_y[i*Y_W +: Y_W];
                sel_value = req_value[i];
            end
        end
    end

    // Next-state, handshake and write-port logic; clear_start beats any request.
    always_comb begin
        state_d    = state_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        we_d       = 1'b0;
        wx_d       = wx_q;
        wy_d       = wy_q;
        wv_d       = wv_q;
        count_d    = count_q;
        grant_ok   = (state_q == ST_IDLE) && !clear_start;
        req_ready  = grant_ok ? grant_onehot : '0;
        transfer   = |(req_valid & req_ready);
        sweep_last = (sx_q == X_LAST) && (sy_q == Y_LAST);

        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    sx_d    = '0;
                    sy_d    = '0;
                    we_d    = 1'b1;
                    wx_d    = '0;
                    wy_d    = '0;
                    wv_d    = CLEAR_VALUE;
                    count_d = '0;
                end else if (transfer) begin
                    we_d = 1'b1;
                    wx_d = sel_x;
                    wy_d = sel_y;
                    wv_d = sel_value;
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_CLEAR: begin
                // sx/sy name the pixel currently on the write port.
                if (sweep_last) begin
                    state_d = ST_IDLE;
                    sx_d    = '0;
                    sy_d    = '0;
                end else begin
                    if (sx_q == X_LAST) begin
                        sx_d = '0;
                        sy_d = sy_q + Y_W'(1);
                    end else begin
                        sx_d = sx_q + X_W'(1);
                    end
                    we_d = 1'b1;
                    wx_d = sx_d;
                    wy_d = sy_d;
                    wv_d = CLEAR_VALUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, sweep counters and registered write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            we_q    <= 1'b0;
            wx_q    <= '0;
            wy_q    <= '0;
            wv_q    <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            we_q    <= we_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            wv_q    <= wv_d;
            busy_q  <= (state_d == ST_CLEAR);
            count_q <= count_d;
        end
    end

    assign clear_busy  = busy_q;
    assign write_en    = we_q;
    assign write_x     = wx_q;
    assign write_y     = wy_q;
    assign write_value = wv_q;
    assign write_count = count_q;

endmodule
